// File: rtl/char_tx_scheduler_if.sv
// Character handshake and serial-line bundle between the two byte sources and the TX scheduler.
interface char_tx_scheduler_if;
  logic [7:0] a_char;
  logic       a_valid;
  logic       a_ready;
  logic [7:0] b_char;
  logic       b_valid;
  logic       b_ready;
  logic       tx;
  logic       busy;
  logic       last_b;

  modport master (
    output a_char, a_valid, b_char, b_valid,
    input  a_ready, b_ready, tx, busy, last_b
  );

  modport slave (
    input  a_char, a_valid, b_char, b_valid,
    output a_ready, b_ready, tx, busy, last_b
  );
endinterface

// File: rtl/char_tx_scheduler.sv
// Round-robin arbiter between two byte sources feeding one 8N1 UART transmitter (LSB first).
module char_tx_scheduler #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int CNT_W        = 14
) (
  input logic            cclk,
  input logic            rst,
  char_tx_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  state_t           r_state;
  logic             r_tx;
  logic             r_last_b;
  logic [2:0]       r_bit;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_shift;

  logic w_win_a, w_win_b, w_acc_a, w_acc_b, w_period_end;

  // On a tie the source that was not served last wins, so continuous requesters alternate.
  assign w_win_a      = bus.a_valid & (~bus.b_valid | r_last_b);
  assign w_win_b      = bus.b_valid & (~bus.a_valid | ~r_last_b);
  assign w_acc_a      = (r_state == IDLE) & w_win_a;
  assign w_acc_b      = (r_state == IDLE) & w_win_b;
  assign w_period_end = (r_cnt == LAST);

  assign bus.a_ready = w_acc_a;
  assign bus.b_ready = w_acc_b;
  assign bus.tx      = r_tx;
  assign bus.busy    = (r_state != IDLE);
  assign bus.last_b  = r_last_b;

  always_ff @(posedge cclk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_tx     <= 1'b1;
      r_last_b <= 1'b1;
      r_bit    <= '0;
      r_cnt    <= '0;
      r_shift  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (w_acc_a | w_acc_b) begin
            r_shift  <= w_acc_a ? bus.a_char : bus.b_char;
            r_last_b <= w_acc_b;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_tx     <= 1'b0;
            r_state  <= START;
          end
        end
        START: begin
          if (w_period_end) begin
            r_cnt   <= '0;
            r_tx    <= r_shift[0];
            r_state <= DATA;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (w_period_end) begin
            r_cnt <= '0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              // tx is registered, so present the next bit while shifting it into place.
              r_bit   <= r_bit + 3'd1;
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (w_period_end) begin
            r_cnt   <= '0;
            r_tx    <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_char_tx_scheduler.sv
// Directed bench for char_tx_scheduler with a frame-level reference model checked every cycle.
module tb_char_tx_scheduler;
  localparam int CPB = 4;
  localparam int FRAME = 10 * CPB;

  logic cclk = 1'b0;
  logic rst  = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  char_tx_scheduler_if bus();

  char_tx_scheduler #(.CLKS_PER_BIT(CPB), .CNT_W(3)) dut (
    .cclk(cclk),
    .rst (rst),
    .bus (bus)
  );

  always #5 cclk = ~cclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a frame is a 10-entry bit list played out CPB cycles per entry.
  logic       mdl_on = 1'b0;
  int         mdl_left = 0;
  int         mdl_pos = 0;
  logic [9:0] mdl_frame = '1;
  logic       mdl_last_b = 1'b1;

  function automatic logic mdl_pick_a();
    return bus.a_valid && (!bus.b_valid || mdl_last_b);
  endfunction
  function automatic logic mdl_pick_b();
    return bus.b_valid && (!bus.a_valid || !mdl_last_b);
  endfunction

  always @(posedge cclk) begin
    cyc++;
    if (rst) begin
      mdl_on = 1'b1; mdl_left = 0; mdl_pos = 0; mdl_last_b = 1'b1;
    end else if (mdl_on) begin
      if (mdl_left > 0) begin
        mdl_left--; mdl_pos++;
      end else if (mdl_pick_a() || mdl_pick_b()) begin
        mdl_frame  = {1'b1, (mdl_pick_a() ? bus.a_char : bus.b_char), 1'b0};
        mdl_last_b = mdl_pick_b();
        mdl_left   = FRAME;
        mdl_pos    = 0;
      end
    end
  end

  // Per-cycle comparison plus accept/ready bookkeeping for the directed checks.
  int a_rdy_cnt = 0, b_rdy_cnt = 0;
  int acc_src[$];
  int acc_cyc[$];

  always @(negedge cclk) begin
    if (!rst && mdl_on) begin
      chk("tx",      32'(bus.tx),      32'(mdl_left > 0 ? mdl_frame[mdl_pos / CPB] : 1'b1));
      chk("busy",    32'(bus.busy),    32'(mdl_left > 0));
      chk("a_ready", 32'(bus.a_ready), 32'(mdl_left == 0 && mdl_pick_a()));
      chk("b_ready", 32'(bus.b_ready), 32'(mdl_left == 0 && mdl_pick_b()));
      chk("last_b",  32'(bus.last_b),  32'(mdl_last_b));
      if (bus.a_ready) a_rdy_cnt++;
      if (bus.b_ready) b_rdy_cnt++;
      if (bus.a_ready && bus.a_valid) begin acc_src.push_back(0); acc_cyc.push_back(cyc); end
      if (bus.b_ready && bus.b_valid) begin acc_src.push_back(1); acc_cyc.push_back(cyc); end
    end
  end

  task automatic do_reset(input logic av, input logic [7:0] ac, input logic bv, input logic [7:0] bc);
    @(posedge cclk); #1;
    rst = 1'b1;
    bus.a_valid = av; bus.a_char = ac; bus.b_valid = bv; bus.b_char = bc;
    repeat (2) @(posedge cclk);
    #1 rst = 1'b0;
    a_rdy_cnt = 0; b_rdy_cnt = 0;
    acc_src.delete(); acc_cyc.delete();
    @(negedge cclk);
  endtask

  // Called right after a negedge; returns at the negedge whose following posedge accepts.
  task automatic wait_accept(input string name);
    int n = 0;
    while (!((bus.a_ready && bus.a_valid) || (bus.b_ready && bus.b_valid)) && n < 200) begin
      @(negedge cclk); n++;
    end
    if (n >= 200) chk({name, "_accept_timeout"}, 32'(n), 32'd0);
  endtask

  // Samples the middle of each bit period and counts busy cycles; mode drives mid-frame input changes.
  task automatic capture(input int mode, output logic [9:0] bits, output int busy_n);
    busy_n = 0; bits = '0;
    for (int n = 1; n <= FRAME; n++) begin
      @(negedge cclk);
      if (bus.busy) busy_n++;
      if (n % CPB == 2) bits[(n - 2) / CPB] = bus.tx;
      if (n == 1 && mode >= 1) bus.a_valid = 1'b0;
      if (n == 1 && mode == 3) bus.b_valid = 1'b1;
      if (n == 2 && mode == 2) bus.a_char = 8'h7E;
      if (n == 2 && mode == 3) bus.b_valid = 1'b0;
      if (n == 2 && mode == 4) bus.b_char = 8'hFF;
      if (n == 1 && mode == 5) bus.b_valid = 1'b0;
    end
    @(negedge cclk);
  endtask

  logic [9:0] bits;
  int         bn;

  initial begin
    bus.a_valid = 1'b0; bus.a_char = '0; bus.b_valid = 1'b0; bus.b_char = '0;

    // 1: single A byte 0x41
    do_reset(1'b0, 8'h00, 1'b0, 8'h00);
    chk("rst_tx", 32'(bus.tx), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_last_b", 32'(bus.last_b), 32'd1);
    @(posedge cclk); #1 bus.a_valid = 1'b1; bus.a_char = 8'h41;
    @(negedge cclk);
    wait_accept("t1");
    capture(1, bits, bn);
    chk("t1_bits", 32'(bits), 32'(10'b1010000010));
    chk("t1_busy_cycles", 32'(bn), 32'd40);
    chk("t1_busy_after", 32'(bus.busy), 32'd0);
    chk("t1_last_b", 32'(bus.last_b), 32'd0);
    chk("t1_a_ready_pulses", 32'(a_rdy_cnt), 32'd1);

    // 2: both held, grants alternate A,B,A,B
    do_reset(1'b1, 8'h55, 1'b1, 8'hAA);
    repeat (4 * (FRAME + 1) + 3) @(negedge cclk);
    chk("t2_accepts", 32'(acc_src.size() >= 4), 32'd1);
    if (acc_src.size() >= 4)
      for (int i = 0; i < 4; i++) begin
        chk("t2_order", 32'(acc_src[i]), 32'(i % 2));
        if (i > 0) chk("t2_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd41);
      end

    // 3: B only, 0x00 then 0xFF back-to-back
    do_reset(1'b0, 8'h00, 1'b1, 8'h00);
    wait_accept("t3a");
    capture(4, bits, bn);
    chk("t3_bits_00", 32'(bits), 32'(10'b1000000000));
    wait_accept("t3b");
    capture(5, bits, bn);
    chk("t3_bits_ff", 32'(bits), 32'(10'b1111111110));
    chk("t3_spacing", 32'(acc_cyc.size() == 2 ? acc_cyc[1] - acc_cyc[0] : 0), 32'd41);

    // 4: reset during DATA bit 3 of an A frame
    do_reset(1'b1, 8'hA5, 1'b0, 8'h00);
    wait_accept("t4a");
    repeat (18) @(negedge cclk);
    @(posedge cclk); #1 rst = 1'b1;
    @(posedge cclk); #1 rst = 1'b0;
    @(negedge cclk);
    chk("t4_tx_after_rst", 32'(bus.tx), 32'd1);
    chk("t4_busy_after_rst", 32'(bus.busy), 32'd0);
    chk("t4_last_b_after_rst", 32'(bus.last_b), 32'd1);
    wait_accept("t4b");
    capture(1, bits, bn);
    chk("t4_bits", 32'(bits), 32'(10'b1101001010));
    chk("t4_busy_cycles", 32'(bn), 32'd40);

    // 5: a_char changes after accept
    do_reset(1'b1, 8'h41, 1'b0, 8'h00);
    wait_accept("t5");
    capture(2, bits, bn);
    chk("t5_bits", 32'(bits), 32'(10'b1010000010));
    repeat (5) @(negedge cclk);
    chk("t5_a_ready_pulses", 32'(a_rdy_cnt), 32'd1);

    // 6: short B request while A frame is busy
    do_reset(1'b1, 8'h33, 1'b0, 8'h00);
    wait_accept("t6");
    capture(3, bits, bn);
    for (int i = 0; i < 6; i++) begin
      chk("t6_tx_idle", 32'(bus.tx), 32'd1);
      chk("t6_busy_idle", 32'(bus.busy), 32'd0);
      @(negedge cclk);
    end
    chk("t6_b_ready_pulses", 32'(b_rdy_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
